// File: rtl/multiplier_8bits_accumulator.sv
// Multiply-accumulate back end: sums N_TERMS consecutive 16-bit products and hands the result off over valid/ready.
// Define MAC_ACC_SATURATE_EN to clamp on overflow and report it on sat; otherwise the accumulator wraps.
module multiplier_8bits_accumulator #(
    parameter int N_TERMS   = 8,
    parameter int ACC_WIDTH = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sat
);

    localparam int CNT_W = $clog2(N_TERMS) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic [ACC_WIDTH-1:0] sum_q;

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]     cnt_next;
    logic                 last_beat;
    logic                 handoff;

    // The only combinational path to an output: out_ready feeds in_ready while a result is held.
    assign in_ready  = (state == ACCUM) ? 1'b1 : out_ready;
    assign out_valid = (state == HOLD);
    assign sum       = sum_q;

    assign prod_ext  = ACC_WIDTH'(product);
    assign cnt_next  = cnt + CNT_ONE;
    assign last_beat = (state == ACCUM) && in_valid && (cnt_next == CNT_LAST);
    assign handoff   = (state == HOLD) && out_ready;

`ifdef MAC_ACC_SATURATE_EN
    logic                 acc_sat;
    logic                 sat_q;
    logic                 sat_next;
    logic [ACC_WIDTH:0]   wide;

    // Once the sticky flag is set the accumulator stays pinned at full scale.
    always_comb begin
        wide     = {1'b0, acc} + {1'b0, prod_ext};
        sat_next = acc_sat | wide[ACC_WIDTH];
        acc_next = sat_next ? {ACC_WIDTH{1'b1}} : wide[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sat <= 1'b0;
            sat_q   <= 1'b0;
        end else if (clear) begin
            acc_sat <= 1'b0;
            sat_q   <= 1'b0;
        end else if (handoff) begin
            acc_sat <= 1'b0;
            sat_q   <= 1'b0;
        end else if ((state == ACCUM) && in_valid) begin
            acc_sat <= sat_next;
            if (last_beat) begin
                sat_q <= sat_next;
            end
        end
    end

    assign sat = sat_q;
`else
    always_comb begin
        acc_next = acc + prod_ext;
    end

    assign sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            sum_q <= '0;
        end else if (clear) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        if (last_beat) begin
                            state <= HOLD;
                            sum_q <= acc_next;
                        end
                    end
                end
                HOLD: begin
                    // A beat accepted during the handoff seeds the next result with zero bubbles.
                    if (out_ready) begin
                        state <= ACCUM;
                        if (in_valid) begin
                            acc <= prod_ext;
                            cnt <= CNT_ONE;
                        end else begin
                            acc <= '0;
                            cnt <= '0;
                        end
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_8bits_accumulator.sv
// Directed testbench for multiplier_8bits_accumulator with hand-computed expected sums.
module tb_multiplier_8bits_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] product;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] sum;
    logic        sat;

    int checks;
    int errors;

    multiplier_8bits_accumulator #(.N_TERMS(8), .ACC_WIDTH(18)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive inputs just after an edge and let combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [15:0] p, input logic r, input logic c);
        in_valid  = v;
        product   = p;
        out_ready = r;
        clear     = c;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] p);
        applyStimulus(1'b1, p, 1'b1, 1'b0);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic idle(input logic r);
        applyStimulus(1'b0, 16'd0, r, 1'b0);
        cycle();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        product   = 16'd0;
        out_ready = 1'b0;

        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_sat", 32'(sat), 32'd0);
        rst_n = 1'b1;
        cycle();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        // Basic accumulate: 8 x 11270
        for (int i = 0; i < 8; i++) begin
            beat(16'd11270);
            if (i == 6) checkOutput("basic_valid_early", 32'(out_valid), 32'd0);
        end
        checkOutput("basic_out_valid", 32'(out_valid), 32'd1);
        checkOutput("basic_sum", 32'(sum), 32'd90160);
        checkOutput("basic_sat", 32'(sat), 32'd0);

        // Backpressure in HOLD with a beat waiting
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'd16830, 1'b0, 1'b0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            cycle();
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_sum", 32'(sum), 32'd90160);
        end
        applyStimulus(1'b1, 16'd16830, 1'b1, 1'b0);
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        cycle();
        checkOutput("bp_handoff_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 7; i++) begin
            beat(16'd0);
            if (i == 5) checkOutput("bp_cnt_seeded_early", 32'(out_valid), 32'd0);
        end
        checkOutput("bp_next_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_next_sum", 32'(sum), 32'd16830);
        idle(1'b1);

        // Overflow: 8 x 65025
        for (int i = 0; i < 8; i++) beat(16'd65025);
        checkOutput("ovf_out_valid", 32'(out_valid), 32'd1);
`ifdef MAC_ACC_SATURATE_EN
        checkOutput("ovf_sum", 32'(sum), 32'd262143);
        checkOutput("ovf_sat", 32'(sat), 32'd1);
`else
        checkOutput("ovf_sum", 32'(sum), 32'd258056);
        checkOutput("ovf_sat", 32'(sat), 32'd0);
`endif
        idle(1'b1);
        checkOutput("ovf_sat_cleared", 32'(sat), 32'd0);

        // Gapped input: 8 x 9618 with two idle cycles between beats
        for (int i = 0; i < 8; i++) begin
            beat(16'd9618);
            if (i < 7) begin
                idle(1'b1);
                idle(1'b1);
                checkOutput("gap_no_valid", 32'(out_valid), 32'd0);
            end
        end
        checkOutput("gap_out_valid", 32'(out_valid), 32'd1);
        checkOutput("gap_sum", 32'(sum), 32'd76944);
        idle(1'b1);

        // Clear mid-accumulation discards partial sum and any concurrent beat
        for (int i = 0; i < 3; i++) beat(16'd11270);
        applyStimulus(1'b1, 16'd5, 1'b1, 1'b1);
        checkOutput("clear_in_ready", 32'(in_ready), 32'd1);
        cycle();
        clear = 1'b0;
        for (int i = 0; i < 8; i++) beat(16'd1);
        checkOutput("clear_out_valid", 32'(out_valid), 32'd1);
        checkOutput("clear_sum", 32'(sum), 32'd8);

        // Clear while holding a result drops it
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        cycle();
        clear = 1'b0;
        checkOutput("clear_hold_valid", 32'(out_valid), 32'd0);

        // Reset after 5 beats
        for (int i = 0; i < 5; i++) beat(16'd11270);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_sum", 32'(sum), 32'd0);
        checkOutput("rst_mid_sat", 32'(sat), 32'd0);
        rst_n = 1'b1;
        cycle();
        for (int i = 0; i < 8; i++) beat(16'd100);
        checkOutput("rst_after_valid", 32'(out_valid), 32'd1);
        checkOutput("rst_after_sum", 32'(sum), 32'd800);

        // Reset while holding a result
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_hold_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_hold_sum", 32'(sum), 32'd0);
        rst_n = 1'b1;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiplier_8bits_accumulator.md
# multiplier_8bits_accumulator

Accumulation stage sitting directly downstream of `multiplier_8bits_version0`. It consumes the 16-bit `product` stream, sums a fixed number of consecutive products into a wider accumulator, and hands the finished sum to the next stage over a valid/ready handshake. It turns the combinational 8x8 multiplier into the multiply-accumulate datapath used for dot products.

## Interface
- `N_TERMS`, 8, number of products summed per result; legal range 2..256.
- `ACC_WIDTH`, 18, accumulator and `sum` width; legal range 16..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous flush; highest priority after reset.
- `in_valid` input 1: `product` carries a valid term.
- `in_ready` output 1: stage accepts a term this cycle.
- `product` input 16: unsigned product taken from `multiplier_8bits_version0`.
- `out_valid` output 1: `sum` holds a completed result.
- `out_ready` input 1: downstream accepts the result.
- `sum` output ACC_WIDTH: completed accumulation, unsigned.
- `sat` output 1: result saturated. Only meaningful when `MAC_ACC_SATURATE_EN` is defined; tied to 0 otherwise.

## Operation
- Internal state:
  - FSM {ACCUM, HOLD}.
  - Accumulator `acc[ACC_WIDTH-1:0]`.
  - Term counter `cnt` of width clog2(N_TERMS)+1.
  - Sticky saturation bit.
- Beat acceptance: a beat is accepted when `in_valid && in_ready`.
- ACCUM state:
  - `in_ready`=1 and `out_valid`=0.
  - Each accepted beat does `acc <= acc + product`, with `product` zero-extended to ACC_WIDTH, and increments `cnt`.
  - The beat that brings `cnt` to N_TERMS moves the FSM to HOLD and registers the final sum into `sum`.
- HOLD state:
  - `out_valid`=1.
  - `sum` and `sat` are stable until the handshake completes.
  - `in_ready` = `out_ready`, driven combinationally.
- Handoff (`out_valid && out_ready`):
  - The FSM returns to ACCUM.
  - If a beat is accepted in the same cycle, `acc <= product` and `cnt <= 1`. Otherwise `acc <= 0` and `cnt <= 0`.
  - The saturation bit clears in either case.
- Wrap/saturation arithmetic:
  - The addition is done at ACC_WIDTH+1 bits.
  - Carry-out handling is chosen by the Configuration macro.
- `clear`:
  - Sets `acc`=0, `cnt`=0 and `sat`=0, and forces the FSM to ACCUM.
  - Drops a pending HOLD result without a handshake.
  - Any beat presented in the same cycle is discarded.
  - `in_ready` remains 1 during `clear`.
- Reset values (`rst_n`=0):
  - FSM=ACCUM, `acc`=0, `cnt`=0, `sum`=0, `sat`=0, `out_valid`=0.
  - `in_ready`=1 once `rst_n` deasserts.
- Reset asserted mid-accumulation or in HOLD discards all partial and pending data immediately, asynchronously.

## Timing
- Throughput: one term per cycle while in ACCUM.
- Latency: `out_valid` rises the cycle after the N_TERMS-th beat is accepted.
- Back-to-back results are possible with zero bubbles: the first term of the next result may be accepted in the handoff cycle.
- No combinational path from `in_valid` or `product` to any output.
- The only combinational path is `out_ready` -> `in_ready`, and it exists in HOLD only.
- `product` must be stable only in cycles where `in_valid`=1.
- `in_valid` may be deasserted for any number of cycles mid-accumulation; `acc` and `cnt` hold their values.

## Configuration
- Macro: `MAC_ACC_SATURATE_EN`.
- Defined:
  - On carry-out, `acc` clamps to 2^ACC_WIDTH-1 and the sticky `sat` sets.
  - Further beats keep `acc` clamped.
  - `sat` is presented with `sum` in HOLD.
- Undefined:
  - The accumulator wraps modulo 2^ACC_WIDTH.
  - `sat` is constant 0 and no saturation logic is synthesised.

## Test plan
- **Basic accumulate:**
  - Stimulus: defaults; after reset, 8 consecutive beats of `product`=11270 (98x115), `out_ready`=1.
  - Required: `out_valid` one cycle after the 8th beat, `sum`=90160, `sat`=0.
- **Backpressure:**
  - Stimulus: as above, but `out_ready`=0 for 3 cycles in HOLD while `in_valid`=1 with `product`=16830.
  - Required: `in_ready`=0, `sum`=90160 stable, and no beat absorbed.
  - Then `out_ready`=1: the handoff accepts 16830, and the next result starts with `acc`=16830, `cnt`=1.
- **Overflow:**
  - Stimulus: 8 beats of 65025 (255x255).
  - Required, macro undefined: `sum`=258056 (520200 mod 2^18), `sat`=0.
  - Required, macro defined: `sum`=262143, `sat`=1.
- **Gapped input:**
  - Stimulus: 8 beats of 9618 (229x42), with `in_valid` low for 2 cycles between each beat.
  - Required: `sum`=76944, `out_valid` exactly one cycle after the last beat.
- **Clear:**
  - Stimulus: 3 beats of 11270, then `clear`=1 for 1 cycle, then 8 beats of 1.
  - Required: `sum`=8.
  - Also: `clear` asserted in HOLD drops `out_valid` the next cycle.
- **Reset mid-operation:**
  - Stimulus: `rst_n` pulsed low after 5 beats.
  - Required: `out_valid`=0, `sum`=0, `sat`=0 immediately.
  - A following run of 8 beats of 100 gives `sum`=800.
